boot_rom: RTL and testbench
===========================

BOOT_ROM -- requirements
Module: boot_rom

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word address width; depth = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, word width; legal values are multiples of 8, range 8..64.
REQ-003 SHALL have parameter INIT_FILE, default "", binary memory image loaded at elaboration; empty means contents start undefined.
REQ-004 SHALL have parameter OUT_REG, default 0, adding an extra output pipeline stage when 1.
REQ-005 SHALL have port i_clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-006 SHALL have port i_rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-007 SHALL have port i_rd_en, input, 1 bit, read request for the current cycle.
REQ-008 SHALL have port i_rd_addr, input, ADDR_WIDTH bits, read word address.
REQ-009 SHALL have port o_rd_data, output, DATA_WIDTH bits, read data.
REQ-010 SHALL have port o_rd_valid, output, 1 bit, one-cycle pulse marking o_rd_data as new.
REQ-011 SHALL have port i_ld_start, input, 1 bit, pulse that begins a load.
REQ-012 SHALL have port i_ld_valid, input, 1 bit, marks i_ld_byte as valid.
REQ-013 SHALL have port i_ld_byte, input, 8 bits, load stream byte.
REQ-014 SHALL have port i_ld_last, input, 1 bit, marks the final byte of the stream.
REQ-015 SHALL have port o_ld_ready, output, 1 bit, high while load bytes are accepted.
REQ-016 SHALL have port o_ld_done, output, 1 bit, one-cycle pulse when a load completes.
REQ-017 SHALL have port o_busy, output, 1 bit, high while in LOAD.

Function
REQ-018 SHALL implement a two-state FSM, IDLE and LOAD; reset enters IDLE.
REQ-019 SHALL transition IDLE->LOAD on i_ld_start, clearing the write pointer and byte counter to 0.
REQ-020 SHALL, in LOAD, assert o_ld_ready and accept a byte on every cycle with i_ld_valid high; bytes arriving while o_ld_ready is low are ignored.
REQ-021 SHALL assemble bytes little-endian, first byte into bits [7:0], and write one word to mem[pointer] on the cycle after its DATA_WIDTH/8-th byte, then increment the pointer.
REQ-022 SHALL, on an accepted byte with i_ld_last high:
  - pad any partial word's unfilled upper bytes with 0 and write it;
  - return to IDLE;
  - pulse o_ld_done one cycle after that final write.
REQ-023 SHALL treat the write of word 2**ADDR_WIDTH-1 as final, ending the load as if i_ld_last were set; the pointer never wraps.
REQ-024 SHALL ignore i_ld_start while already in LOAD.
REQ-025 SHALL service reads only in IDLE; in LOAD, i_rd_en is ignored and o_rd_valid stays 0.
REQ-026 SHALL, for a read in IDLE, return mem[i_rd_addr] with o_rd_valid after 1+OUT_REG cycles.
REQ-027 SHALL be fully pipelined, accepting one read per cycle.
REQ-028 SHALL hold o_rd_data between reads.
REQ-029 SHALL resolve a read issued on the same cycle as i_ld_start as follows:
  - the read completes with pre-load data;
  - reads already in flight complete normally.
REQ-030 SHALL keep memory contents non-resettable; they persist across resets.

Reset
REQ-031 SHALL, on asserting i_rst_n low, immediately clear:
  - o_rd_data to 0;
  - o_rd_valid, o_ld_ready, o_ld_done and o_busy to 0;
  - the FSM to IDLE;
  - the pointer, the byte counter and the pipeline valids.
REQ-032 SHALL handle reset during LOAD as follows:
  - discard the partial word;
  - words already written remain;
  - no o_ld_done is produced.
REQ-033 SHALL resume normal operation on the first rising edge after i_rst_n deasserts.

Verification
REQ-034 SHALL pass an init read test: with an INIT_FILE where word0=16'h7100 and word1=16'h7103, reading address 0 then address 1 back-to-back (OUT_REG=0) -> o_rd_valid on cycles 1 and 2, returning 16'h7100 then 16'h7103.
REQ-035 SHALL pass a load test: i_ld_start, then bytes 8'h34, 8'h12, 8'hCD, 8'hAB with last on 8'hAB -> mem[0]=16'h1234, mem[1]=16'hABCD, one o_ld_done pulse, and readback matches.
REQ-036 SHALL pass an odd-byte last test: load 8'h55 with i_ld_last -> mem[0]=16'h0055, and mem[1] is unchanged.
REQ-037 SHALL pass a reset mid-load test: reset after 3 bytes of the REQ-035 stream -> mem[0]=16'h1234, mem[1] is unchanged, o_busy=0, and no o_ld_done.
REQ-038 SHALL pass an OUT_REG=1 test: reads on 4 consecutive cycles -> 4 valid pulses, each two cycles after its request, in order.
REQ-039 SHALL pass a full-depth test: with ADDR_WIDTH=2, streaming 10 bytes without i_ld_last -> four words written, o_ld_done after the 8th byte, and bytes 9-10 ignored (o_ld_ready=0).

Source files
------------

// File: rtl/boot_rom.sv
// Boot ROM with a byte-stream loader: bytes are packed little-endian into words
// and written sequentially from address 0; reads are served only while idle.
//   state  | meaning
//   S_IDLE | reads serviced, waiting for i_ld_start
//   S_LOAD | accepting load bytes, reads ignored
module boot_rom #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter     INIT_FILE  = "",
  parameter int OUT_REG    = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  input  logic                  i_ld_start,
  input  logic                  i_ld_valid,
  input  logic [7:0]            i_ld_byte,
  input  logic                  i_ld_last,
  output logic                  o_ld_ready,
  output logic                  o_ld_done,
  output logic                  o_busy
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int BYTES = DATA_WIDTH / 8;

  typedef enum logic {S_IDLE, S_LOAD} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [3:0]            byte_cnt;
  logic [DATA_WIDTH-1:0] word_buf;
  logic [DATA_WIDTH-1:0] nxt_word;
  logic                  wr_en;
  logic                  wr_final;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  accept;
  logic                  word_full;
  logic                  emit;
  logic                  finish;

  // word_buf is cleared after every emitted word, so a short final word is zero-padded
  always_comb begin
    nxt_word = word_buf;
    nxt_word[8*int'(byte_cnt) +: 8] = i_ld_byte;
  end

  assign accept    = (state == S_LOAD) && i_ld_valid;
  assign word_full = (byte_cnt == 4'(BYTES-1));
  assign emit      = accept && (word_full || i_ld_last);
  assign finish    = emit && (i_ld_last || (&ptr));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      ptr        <= '0;
      byte_cnt   <= '0;
      word_buf   <= '0;
      wr_en      <= 1'b0;
      wr_final   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      o_ld_ready <= 1'b0;
      o_ld_done  <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      wr_final  <= 1'b0;
      o_ld_done <= wr_en && wr_final;
      case (state)
        S_IDLE: begin
          if (i_ld_start) begin
            state      <= S_LOAD;
            ptr        <= '0;
            byte_cnt   <= '0;
            word_buf   <= '0;
            o_ld_ready <= 1'b1;
            o_busy     <= 1'b1;
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (emit) begin
              wr_en    <= 1'b1;
              wr_final <= finish;
              wr_addr  <= ptr;
              wr_data  <= nxt_word;
              word_buf <= '0;
              byte_cnt <= '0;
              // pointer saturates at the top word; that write ends the load
              if (!(&ptr)) ptr <= ptr + ADDR_WIDTH'(1);
              if (finish) begin
                state      <= S_IDLE;
                o_ld_ready <= 1'b0;
                o_busy     <= 1'b0;
              end
            end else begin
              word_buf <= nxt_word;
              byte_cnt <= byte_cnt + 4'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  logic                  rd_ok;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  rd_v;

  assign rd_ok = i_rd_en && (state == S_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_q <= '0;
      rd_v <= 1'b0;
    end else begin
      rd_v <= rd_ok;
      if (rd_ok) rd_q <= mem[i_rd_addr];
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] out_q;
      logic                  out_v;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          out_q <= '0;
          out_v <= 1'b0;
        end else begin
          out_v <= rd_v;
          if (rd_v) out_q <= rd_q;
        end
      end
      assign o_rd_data  = out_q;
      assign o_rd_valid = out_v;
    end else begin : g_no_out_reg
      assign o_rd_data  = rd_q;
      assign o_rd_valid = rd_v;
    end
  endgenerate

endmodule

// File: tb/tb_boot_rom.sv
// Scoreboard bench for boot_rom: instance a uses defaults, instance b uses
// ADDR_WIDTH=2 with OUT_REG=1 for the full-depth and pipelined-read cases.
module tb_boot_rom;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic        a_rd_en, a_rd_valid, a_ld_start, a_ld_valid, a_ld_last, a_ld_ready, a_ld_done, a_busy;
  logic [9:0]  a_rd_addr;
  logic [15:0] a_rd_data;
  logic [7:0]  a_ld_byte;

  logic        b_rd_en, b_rd_valid, b_ld_start, b_ld_valid, b_ld_last, b_ld_ready, b_ld_done, b_busy;
  logic [1:0]  b_rd_addr;
  logic [15:0] b_rd_data;
  logic [7:0]  b_ld_byte;

  boot_rom dut_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rd_en(a_rd_en), .i_rd_addr(a_rd_addr), .o_rd_data(a_rd_data), .o_rd_valid(a_rd_valid),
    .i_ld_start(a_ld_start), .i_ld_valid(a_ld_valid), .i_ld_byte(a_ld_byte), .i_ld_last(a_ld_last),
    .o_ld_ready(a_ld_ready), .o_ld_done(a_ld_done), .o_busy(a_busy)
  );

  boot_rom #(.ADDR_WIDTH(2), .OUT_REG(1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rd_en(b_rd_en), .i_rd_addr(b_rd_addr), .o_rd_data(b_rd_data), .o_rd_valid(b_rd_valid),
    .i_ld_start(b_ld_start), .i_ld_valid(b_ld_valid), .i_ld_byte(b_ld_byte), .i_ld_last(b_ld_last),
    .o_ld_ready(b_ld_ready), .o_ld_done(b_ld_done), .o_busy(b_busy)
  );

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   a_done_cnt = 0;
  int   b_done_cnt = 0;
  int   b_done_cyc = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: pops the scoreboard whenever a DUT presents read data
  always @(negedge clk) begin
    exp_t e;
    if (a_ld_done) a_done_cnt++;
    if (b_ld_done) begin
      b_done_cnt++;
      b_done_cyc = cyc;
    end
    if (a_rd_valid) begin
      if (qa.size() == 0) begin
        tests++; fails++;
        $display("FAIL a_unexpected_valid: got data %0h with no read outstanding", a_rd_data);
      end else begin
        e = qa.pop_front();
        chk("a_rd_data", a_rd_data, e.data);
        chk("a_rd_latency_cycle", cyc, e.cyc);
      end
    end
    if (b_rd_valid) begin
      if (qb.size() == 0) begin
        tests++; fails++;
        $display("FAIL b_unexpected_valid: got data %0h with no read outstanding", b_rd_data);
      end else begin
        e = qb.pop_front();
        chk("b_rd_data", b_rd_data, e.data);
        chk("b_rd_latency_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic a_start();
    a_ld_start = 1'b1;
    idle(1);
    a_ld_start = 1'b0;
  endtask

  task automatic a_byte(input logic [7:0] b, input logic last);
    a_ld_valid = 1'b1; a_ld_byte = b; a_ld_last = last;
    idle(1);
    a_ld_valid = 1'b0; a_ld_last = 1'b0;
  endtask

  task automatic a_rd(input logic [9:0] addr, input logic [15:0] exp);
    exp_t e;
    e.data = exp; e.cyc = cyc + 1;
    qa.push_back(e);
    a_rd_en = 1'b1; a_rd_addr = addr;
    idle(1);
  endtask

  task automatic b_byte(input logic [7:0] b, output logic acc);
    acc = b_ld_ready;
    b_ld_valid = 1'b1; b_ld_byte = b; b_ld_last = 1'b0;
    idle(1);
    b_ld_valid = 1'b0;
  endtask

  task automatic b_rd(input logic [1:0] addr, input logic [15:0] exp);
    exp_t e;
    e.data = exp; e.cyc = cyc + 2;
    qb.push_back(e);
    b_rd_en = 1'b1; b_rd_addr = addr;
    idle(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   d8;
    d8 = 0;
    rst_n = 1'b0;
    a_rd_en = 0; a_rd_addr = '0; a_ld_start = 0; a_ld_valid = 0; a_ld_byte = '0; a_ld_last = 0;
    b_rd_en = 0; b_rd_addr = '0; b_ld_start = 0; b_ld_valid = 0; b_ld_byte = '0; b_ld_last = 0;

    @(negedge clk);
    chk("a_reset_rd_data", a_rd_data, 16'h0);
    chk("a_reset_rd_valid", a_rd_valid, 0);
    chk("a_reset_ld_ready", a_ld_ready, 0);
    chk("a_reset_ld_done", a_ld_done, 0);
    chk("a_reset_busy", a_busy, 0);
    chk("b_reset_rd_data", b_rd_data, 16'h0);
    chk("b_reset_busy", b_busy, 0);
    idle(1);
    rst_n = 1'b1;
    idle(1);

    // image 7100/7103, then back-to-back reads
    a_start();
    chk("a_busy_in_load", a_busy, 1);
    chk("a_ready_in_load", a_ld_ready, 1);
    a_byte(8'h00, 0); a_byte(8'h71, 0); a_byte(8'h03, 0); a_byte(8'h71, 1);
    chk("a_busy_after_last", a_busy, 0);
    idle(3);
    chk("a_done_count_1", a_done_cnt, 1);
    a_rd(10'd0, 16'h7100); a_rd(10'd1, 16'h7103);
    a_rd_en = 1'b0;
    idle(3);

    // four-byte load
    a_start();
    a_byte(8'h34, 0); a_byte(8'h12, 0); a_byte(8'hCD, 0); a_byte(8'hAB, 1);
    idle(3);
    chk("a_done_count_2", a_done_cnt, 2);
    a_rd(10'd1, 16'hABCD); a_rd(10'd0, 16'h1234);
    a_rd_en = 1'b0;
    idle(3);
    chk("a_rd_data_held", a_rd_data, 16'h1234);

    // single byte with last: zero-padded
    a_start();
    a_byte(8'h55, 1);
    idle(3);
    chk("a_done_count_3", a_done_cnt, 3);
    a_rd(10'd0, 16'h0055); a_rd(10'd1, 16'hABCD);
    a_rd_en = 1'b0;
    idle(2);

    // reset after three bytes
    a_start();
    a_byte(8'h34, 0); a_byte(8'h12, 0); a_byte(8'hCD, 0);
    rst_n = 1'b0;
    #1;
    chk("a_busy_async_reset", a_busy, 0);
    chk("a_ready_async_reset", a_ld_ready, 0);
    idle(1);
    rst_n = 1'b1;
    idle(3);
    chk("a_no_done_after_reset", a_done_cnt, 3);
    a_rd(10'd0, 16'h1234); a_rd(10'd1, 16'hABCD);
    a_rd_en = 1'b0;
    idle(2);

    // read with start, read during load, start ignored in load
    begin
      exp_t e;
      e.data = 16'h1234; e.cyc = cyc + 1;
      qa.push_back(e);
    end
    a_rd_en = 1'b1; a_rd_addr = 10'd0; a_ld_start = 1'b1;
    idle(1);
    a_ld_start = 1'b0; a_rd_addr = 10'd1;
    idle(1);
    a_rd_en = 1'b0;
    a_byte(8'hEF, 0);
    a_start();
    a_byte(8'hBE, 1);
    idle(3);
    chk("a_done_count_4", a_done_cnt, 4);
    a_rd(10'd0, 16'hBEEF); a_rd(10'd1, 16'hABCD);
    a_rd_en = 1'b0;
    idle(3);

    // full depth on the 4-word instance
    b_ld_start = 1'b1;
    idle(1);
    b_ld_start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 8) d8 = cyc;
      b_byte(8'(i), acc);
      chk($sformatf("b_ready_byte%0d", i), acc, (i <= 8) ? 1 : 0);
    end
    idle(3);
    chk("b_done_count", b_done_cnt, 1);
    chk("b_done_cycle", b_done_cyc, d8 + 2);
    chk("b_busy_after_full", b_busy, 0);
    b_rd(2'd0, 16'h0201); b_rd(2'd1, 16'h0403); b_rd(2'd2, 16'h0605); b_rd(2'd3, 16'h0807);
    b_rd_en = 1'b0;
    idle(5);

    chk("a_scoreboard_drained", qa.size(), 0);
    chk("b_scoreboard_drained", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
